// File: rtl/gf233_pkg.sv
// Shared types and helpers for the GF(2^233) multiplier arbiter.
// Bypass detection lives here so other point-arithmetic blocks can reuse it.
package gf233_pkg;

    localparam int GF_M         = 233;
    localparam int MULT_LAT_DEF = 4;

    typedef logic [GF_M-1:0] gf233_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   hit;
        gf233_t prod;
    } bypass_t;

    // Products with a 0 or 1 operand need no reduction and skip the multiplier.
    function automatic bypass_t is_trivial_mul(input gf233_t a, input gf233_t b);
        bypass_t r;
        r.hit  = 1'b1;
        r.prod = '0;
        if (a == '0 || b == '0) begin
            r.prod = '0;
        end else if (a == gf233_t'(1)) begin
            r.prod = b;
        end else if (b == gf233_t'(1)) begin
            r.prod = a;
        end else begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester above last_grant
// (with wrap) wins, so the previous winner gets lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_grant) + k) % NREQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gf233_mult_arbiter.sv
// Round-robin arbiter sharing one external GF(2^233) multiplier among NREQ
// client FSMs; trivial products complete in one cycle without the multiplier.
module gf233_mult_arbiter
    import gf233_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = MULT_LAT_DEF,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*GF_M-1:0] req_a,
    input  logic [NREQ*GF_M-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [GF_M-1:0]      resp_data,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy,
    output logic [GF_M-1:0]      mult_a,
    output logic [GF_M-1:0]      mult_b,
    input  logic [GF_M-1:0]      mult_c
);

    localparam int CW = $clog2(MULT_LAT + 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    gf233_t          ma_q, ma_d;
    gf233_t          mb_q, mb_d;
    logic [NREQ-1:0] rv_q, rv_d;
    gf233_t          rd_q, rd_d;
    logic [IDW-1:0]  rid_q, rid_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    gf233_t          a_sel, b_sel;
    bypass_t         bp;
    logic            hs;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                a_sel = req_a[i*GF_M +: GF_M];
                b_sel = req_b[i*GF_M +: GF_M];
            end
        end
    end

    assign bp = is_trivial_mul(a_sel, b_sel);
    assign hs = (state_q == ST_IDLE) && pick_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs && !bp.hit) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == CW'(MULT_LAT - 1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are suppressed during reset so no client sees a phantom handshake.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && rst_n) begin
            req_ready = pick_gnt;
        end
    end

    always_comb begin
        last_d = last_q;
        id_d   = id_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ma_d   = ma_q;
        mb_d   = mb_q;
        rv_d   = '0;
        rd_d   = rd_q;
        rid_d  = rid_q;
        if (state_q == ST_IDLE) begin
            if (hs) begin
                last_d = pick_idx;
                id_d   = pick_idx;
                if (bp.hit) begin
                    rv_d[pick_idx] = 1'b1;
                    rd_d           = bp.prod;
                    rid_d          = pick_idx;
                end else begin
                    ma_d   = a_sel;
                    mb_d   = b_sel;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(MULT_LAT - 1)) begin
                rv_d[id_q] = 1'b1;
                rd_d       = mult_c;
                rid_d      = id_q;
                busy_d     = 1'b0;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
            id_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ma_q   <= '0;
            mb_q   <= '0;
            rv_q   <= '0;
            rd_q   <= '0;
            rid_q  <= '0;
        end else begin
            last_q <= last_d;
            id_q   <= id_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            rv_q   <= rv_d;
            rd_q   <= rd_d;
            rid_q  <= rid_d;
        end
    end

    assign resp_valid = rv_q;
    assign resp_data  = rd_q;
    assign resp_id    = rid_q;
    assign busy       = busy_q;
    assign mult_a     = ma_q;
    assign mult_b     = mb_q;

endmodule

// File: doc/gf233_mult_arbiter.md
# gf233_mult_arbiter

Shared-multiplier arbiter for the GF(2^233) point-arithmetic layer. It accepts multiply requests from up to NREQ client FSMs (point doubling, point addition, inversion, scalar-mult control), grants one at a time in round-robin order, and drives the single external gf2m_mult233 instance. It returns each product to its requester with a one-cycle tagged pulse. Trivial products (operand 0 or 1) bypass the multiplier and complete in one cycle.

## Interface
- NREQ, 4, number of requesters (2..8)
- MULT_LAT, 4, rising edges from the edge that loads mult_a/mult_b to the edge that samples mult_c
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request; held with operands stable until handshake
- req_a  in  NREQ*233  operand A, requester i at bits [233*i+232 : 233*i]
- req_b  in  NREQ*233  operand B, same packing
- req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
- resp_valid  out  NREQ  one-hot, one-cycle result pulse; no backpressure
- resp_data  out  233  product, valid while any resp_valid bit is high
- resp_id  out  clog2(NREQ)  index of the responding requester
- busy  out  1  multiplier op in flight
- mult_a, mult_b  out  233  registered multiplier operands
- mult_c  in  233  multiplier product

## Operation
- States: IDLE and BUSY.
- IDLE:
  - Combinational round-robin pick among req_valid, searching from last_grant+1 upward with wrap.
  - req_ready = one-hot pick. In BUSY, or while rst_n is low, req_ready = 0.
- On handshake, requester index i is recorded and last_grant <= i.
  - Trivial case: a==0 or b==0 → 0; a==1 → b; b==1 → a. The edge registers resp_data, resp_id = i and resp_valid[i] = 1. The FSM stays in IDLE and mult_a/mult_b are unchanged.
  - Otherwise: mult_a <= a, mult_b <= b, cnt <= 0, busy <= 1, state → BUSY.
- BUSY:
  - cnt increments each edge.
  - The edge where cnt == MULT_LAT-1 registers resp_data <= mult_c, resp_id and resp_valid[id]. The same edge sets busy <= 0 and returns the FSM to IDLE.
  - mult_a/mult_b stay stable throughout BUSY.
- resp_valid clears on the following edge unless a new bypass handshake sets it again. Back-to-back bypass handshakes therefore give consecutive pulses.
- A requester may re-request in the same cycle its resp_valid is high. It is then eligible under round-robin order.
- A requester must not deassert req_valid before handshake. Behaviour is unspecified if it does.

## Timing
- Reset (async assert), all outputs and state: state IDLE, last_grant = NREQ-1 (requester 0 wins first), cnt 0, busy 0, resp_valid 0, resp_data 0, resp_id 0, mult_a 0, mult_b 0, req_ready 0.
- Reset mid-BUSY drops the in-flight product. No resp_valid is issued, either during reset or after it.
- Multiplier path:
  - Handshake at edge E0; mult_c sampled at E0+MULT_LAT.
  - resp_valid high in the cycle following E0+MULT_LAT.
  - Next grant is possible in that same cycle.
  - Throughput: one multiply per MULT_LAT+1 cycles.
- Bypass path: handshake at E0; resp_valid high in the cycle after E0. A new grant is possible every cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers hold valid and are guaranteed service within NREQ grants.

## Structure
- Package gf233_pkg holds:
  - GF_M = 233 and typedef gf233_t = logic [232:0].
  - Default MULT_LAT.
  - Function is_trivial_mul(a,b) returning a bypass flag and the bypass product.
- Sub-module rr_pick, combinational: inputs req vector and last_grant; outputs one-hot grant, grant index and any-valid.
- The top level holds the FSM, counter, operand and response registers. gf2m_mult233 is instantiated by the parent.

## Test plan
- Single multiply: after reset, requester 0 sends a=0x2, b=0x3 → req_ready[0] in the same cycle; mult_a=2, mult_b=3; resp_valid[0] for one cycle, MULT_LAT+1 cycles after handshake, resp_data=0x6, resp_id=0.
- Reduction: a=1<<232, b=2 → resp_data = (1<<74)|1.
- Round-robin: all 4 requesters valid continuously with non-trivial operands → grant order 0,1,2,3,0,1. Each response tagged with the correct id; no grant while busy=1.
- Bypass: requester 1 sends a=1, b=0x1ABC → resp_valid[1] in the next cycle, resp_data=0x1ABC, busy stays 0, mult_a/mult_b unchanged. Next, a=0x55, b=0 → resp_data=0 one cycle later.
- Late arrival: requester 2 raises valid during BUSY → req_ready[2]=0 until the cycle resp_valid pulses, then granted in that cycle.
- Reset mid-BUSY: pull rst_n low at cnt=1 → all outputs immediately 0; no resp_valid after release. The next simultaneous requests grant requester 0 first.
